// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                  fp;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_priority_arbiter.sv
// Fixed-priority two-way grant (wb0 first) with a starvation counter that
// forces wb1 through after STARVE_LIMIT consecutive denials.
module wb_priority_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb0_valid,
  input  logic             wb1_valid,
  output logic             grant0,
  output logic             grant1,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic starved;

  assign starved = (starve_cnt == LIMIT);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      grant1 = wb1_valid && (!wb0_valid || starved);
      grant0 = wb0_valid && !grant1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!wb1_valid || grant1) begin
      starve_cnt <= '0;
    end else if (starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates two write-back sources onto the register file write port through
// one registered stage, forwarding the staged write to both read ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb0_valid,
  output logic        wb0_ready,
  input  logic        wb0_fp,
  input  logic [4:0]  wb0_addr,
  input  logic [31:0] wb0_data,
  input  logic        wb1_valid,
  output logic        wb1_ready,
  input  logic        wb1_fp,
  input  logic [4:0]  wb1_addr,
  input  logic [31:0] wb1_data,
  output logic        rf_WrEn,
  output logic        rf_ftpt_write,
  output logic [4:0]  rf_WrAddr,
  output logic [31:0] rf_WData,
  input  logic        rd_fp,
  input  logic [4:0]  rd_addr1,
  input  logic [4:0]  rd_addr2,
  input  logic [31:0] rf_RData1,
  input  logic [31:0] rf_RData2,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2
);

  logic             grant0, grant1;
  logic [CNT_W-1:0] starve_cnt;
  wb_req_t          wb0_req, wb1_req, req_p0;
  logic             vld_p0, is_zero_p0;

  logic                  vld_p1;
  logic                  fp_p1;
  logic [REG_ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0]     data_p1;

  wb_priority_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .wb0_valid  (wb0_valid),
    .wb1_valid  (wb1_valid),
    .grant0     (grant0),
    .grant1     (grant1),
    .starve_cnt (starve_cnt)
  );

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;

  assign wb0_req = '{fp: wb0_fp, addr: wb0_addr, data: wb0_data};
  assign wb1_req = '{fp: wb1_fp, addr: wb1_addr, data: wb1_data};

  // p0: select the granted request
  assign req_p0     = grant1 ? wb1_req : wb0_req;
  assign vld_p0     = grant0 | grant1;
  assign is_zero_p0 = !req_p0.fp && (req_p0.addr == ZERO_REG);

  // p1: registered write stage; integer r0 writes are accepted but never enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      fp_p1   <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0 && !is_zero_p0;
      if (vld_p0) begin
        fp_p1   <= req_p0.fp;
        addr_p1 <= req_p0.addr;
        data_p1 <= req_p0.data;
      end
    end
  end

  assign rf_WrEn       = vld_p1;
  assign rf_ftpt_write = fp_p1;
  assign rf_WrAddr     = addr_p1;
  assign rf_WData      = data_p1;

  assign rd_data1 = (vld_p1 && (fp_p1 == rd_fp) && (addr_p1 == rd_addr1)) ? data_p1 : rf_RData1;
  assign rd_data2 = (vld_p1 && (fp_p1 == rd_fp) && (addr_p1 == rd_addr2)) ? data_p1 : rf_RData2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the write port.
module tb_regfile_wb_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb0_valid, wb0_ready, wb0_fp;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb1_valid, wb1_ready, wb1_fp;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        rf_WrEn, rf_ftpt_write;
  logic [4:0]  rf_WrAddr;
  logic [31:0] rf_WData;
  logic        rd_fp;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rf_RData1, rf_RData2, rd_data1, rd_data2;

  regfile_wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_fp(wb0_fp),
    .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_fp(wb1_fp),
    .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rf_WrEn(rf_WrEn), .rf_ftpt_write(rf_ftpt_write),
    .rf_WrAddr(rf_WrAddr), .rf_WData(rf_WData),
    .rd_fp(rd_fp), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rf_RData1(rf_RData1), .rf_RData2(rf_RData2),
    .rd_data1(rd_data1), .rd_data2(rd_data2)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the last accepted write and how long wb1 has waited.
  bit          m_en, m_fp;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_wait;
  bit          last_g0, last_g1;
  logic        obs_r0, obs_r1;
  logic [31:0] obs_rd1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic step();
    bit g0, g1, zero;
    logic [31:0] e1, e2;
    #3;
    if (rst) begin
      g0 = 0; g1 = 0;
    end else if (wb0_valid && wb1_valid) begin
      g1 = (m_wait >= STARVE_LIMIT);
      g0 = !g1;
    end else begin
      g0 = wb0_valid; g1 = wb1_valid;
    end
    obs_r0 = wb0_ready; obs_r1 = wb1_ready; obs_rd1 = rd_data1;
    check("wb0_ready", 32'(wb0_ready), 32'(g0));
    check("wb1_ready", 32'(wb1_ready), 32'(g1));
    e1 = (m_en && m_fp == rd_fp && m_addr == rd_addr1) ? m_data : rf_RData1;
    e2 = (m_en && m_fp == rd_fp && m_addr == rd_addr2) ? m_data : rf_RData2;
    check("rd_data1", rd_data1, e1);
    check("rd_data2", rd_data2, e2);
    @(posedge clk);
    if (rst) begin
      m_en = 0; m_fp = 0; m_addr = 0; m_data = 0; m_wait = 0;
    end else begin
      if (g0) begin
        zero = !wb0_fp && wb0_addr == 5'd0;
        m_en = !zero; m_fp = wb0_fp; m_addr = wb0_addr; m_data = wb0_data;
      end else if (g1) begin
        zero = !wb1_fp && wb1_addr == 5'd0;
        m_en = !zero; m_fp = wb1_fp; m_addr = wb1_addr; m_data = wb1_data;
      end else begin
        m_en = 0;
      end
      if (!wb1_valid || g1) m_wait = 0;
      else if (m_wait < STARVE_LIMIT) m_wait = m_wait + 1;
    end
    last_g0 = g0; last_g1 = g1;
    #1;
    check("rf_WrEn", 32'(rf_WrEn), 32'(m_en));
    check("rf_ftpt_write", 32'(rf_ftpt_write), 32'(m_fp));
    check("rf_WrAddr", 32'(rf_WrAddr), 32'(m_addr));
    check("rf_WData", rf_WData, m_data);
    check("starve_cnt", 32'(dut.u_arb.starve_cnt), 32'(m_wait));
  endtask

  initial begin
    rst = 1; wb0_valid = 0; wb0_fp = 0; wb0_addr = 0; wb0_data = 0;
    wb1_valid = 0; wb1_fp = 0; wb1_addr = 0; wb1_data = 0;
    rd_fp = 0; rd_addr1 = 0; rd_addr2 = 0; rf_RData1 = 0; rf_RData2 = 0;
    m_en = 0; m_fp = 0; m_addr = 0; m_data = 0; m_wait = 0;
    @(posedge clk); #1;
    wb0_valid = 1;
    step();
    check("rst_ready0", 32'(obs_r0), 32'd0);
    check("rst_WrEn", 32'(rf_WrEn), 32'd0);
    rst = 0; wb0_valid = 0;
    step();

    // wb0 writes int r1
    wb0_valid = 1; wb0_fp = 0; wb0_addr = 5'd1; wb0_data = 32'h2ae42;
    step();
    check("t1_ready", 32'(obs_r0), 32'd1);
    check("t1_WData", rf_WData, 32'h2ae42);
    check("t1_WrAddr", 32'(rf_WrAddr), 32'd1);
    wb0_valid = 0;
    step();
    check("t1_WrEn_off", 32'(rf_WrEn), 32'd0);

    // both valid continuously: wb1 wins every fifth cycle
    wb0_valid = 1; wb0_fp = 0; wb0_addr = 5'd4;
    wb1_valid = 1; wb1_fp = 1; wb1_addr = 5'd5;
    for (int k = 0; k < 10; k++) begin
      wb0_data = 32'h100 + 32'(k); wb1_data = 32'h200 + 32'(k);
      step();
      check("t2_wb1_win", 32'(obs_r1), 32'((k % 5) == 4));
    end
    wb0_valid = 0; wb1_valid = 0;
    step();

    // wb1 writes FP f3, forwarded only to FP reads
    wb1_valid = 1; wb1_fp = 1; wb1_addr = 5'd3; wb1_data = 32'hfde546;
    step();
    wb1_valid = 0;
    rd_fp = 1; rd_addr1 = 5'd3; rf_RData1 = 32'h0;
    #1;
    check("t3_fwd", rd_data1, 32'hfde546);
    rd_fp = 0; rf_RData1 = 32'h1234;
    #1;
    check("t3_int_nofwd", rd_data1, 32'h1234);
    step();

    // integer r0 write: accepted, never enabled, never forwarded
    wb0_valid = 1; wb0_fp = 0; wb0_addr = 5'd0; wb0_data = 32'h8b004e;
    step();
    check("t4_ready", 32'(obs_r0), 32'd1);
    check("t4_WrEn", 32'(rf_WrEn), 32'd0);
    wb0_valid = 0; rd_fp = 0; rd_addr1 = 5'd0; rf_RData1 = 32'h55;
    step();
    check("t4_rd_r0", obs_rd1, 32'h55);

    // wb1 alone for three cycles
    wb1_valid = 1; wb1_fp = 0; wb1_addr = 5'd7;
    for (int k = 0; k < 3; k++) begin
      wb1_data = 32'hA000 + 32'(k * 17);
      step();
      check("t5_ready", 32'(obs_r1), 32'd1);
      check("t5_WrEn", 32'(rf_WrEn), 32'd1);
    end
    wb1_valid = 0;
    step();

    // reset right after a grant drops the staged write
    wb0_valid = 1; wb0_fp = 0; wb0_addr = 5'd2; wb0_data = 32'h32137;
    step();
    rst = 1; wb1_valid = 1;
    step();
    check("t6_ready0", 32'(obs_r0), 32'd0);
    check("t6_ready1", 32'(obs_r1), 32'd0);
    check("t6_WrEn", 32'(rf_WrEn), 32'd0);
    rst = 0; wb0_valid = 0; wb1_valid = 0;
    step();

    // randomized traffic with requesters holding until accepted
    for (int n = 0; n < 400; n++) begin
      if (!wb0_valid || last_g0) begin
        wb0_valid = ($urandom_range(0, 3) != 0);
        wb0_fp = 1'($urandom_range(0, 1));
        wb0_addr = 5'($urandom_range(0, 3));
        wb0_data = $urandom;
      end
      if (!wb1_valid || last_g1) begin
        wb1_valid = ($urandom_range(0, 3) != 0);
        wb1_fp = 1'($urandom_range(0, 1));
        wb1_addr = 5'($urandom_range(0, 3));
        wb1_data = $urandom;
      end
      rst = ($urandom_range(0, 59) == 0);
      rd_fp = 1'($urandom_range(0, 1));
      rd_addr1 = 5'($urandom_range(0, 3));
      rd_addr2 = 5'($urandom_range(0, 3));
      rf_RData1 = $urandom;
      rf_RData2 = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
